alu_rs: RTL

- Reservation station directly upstream of the ALU.
- Accepts decoded ALU ops from dispatch and holds them until both operands are available.
- Operands are captured from two result broadcast buses (ALU writeback and LSU writeback).
- Issues at most one ready op per cycle to the ALU on its registered operand/tag/name/opcode interface.

---
 rtl/alu_rs_if.sv | 47 ++++
 rtl/alu_rs.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 5
);
  logic              dispEn;
  logic [OP_W-1:0]   dispOp;
  logic [DATA_W-1:0] dispDataO;
  logic [TAG_W-1:0]  dispTagO;
  logic [DATA_W-1:0] dispDataT;
  logic [TAG_W-1:0]  dispTagT;
  logic [TAG_W-1:0]  dispWrtTag;
  logic [NAME_W-1:0] dispWrtName;
  logic              rsFull;
  logic              cdbAEn;
  logic [TAG_W-1:0]  cdbATag;
  logic [DATA_W-1:0] cdbAData;
  logic              cdbLEn;
  logic [TAG_W-1:0]  cdbLTag;
  logic [DATA_W-1:0] cdbLData;
  logic              ALUworkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;

  modport master (
    output dispEn, dispOp, dispDataO, dispTagO,
    output dispDataT, dispTagT, dispWrtTag, dispWrtName,
    output cdbAEn, cdbATag, cdbAData,
    output cdbLEn, cdbLTag, cdbLData,
    input  rsFull, ALUworkEn, operandO, operandT,
    input  wrtTag, wrtName, opCode
  );

  modport slave (
    input  dispEn, dispOp, dispDataO, dispTagO,
    input  dispDataT, dispTagT, dispWrtTag, dispWrtName,
    input  cdbAEn, cdbATag, cdbAData,
    input  cdbLEn, cdbLTag, cdbLData,
    output rsFull, ALUworkEn, operandO, operandT,
    output wrtTag, wrtName, opCode
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are
// captured from the result buses, then issues one ready op per cycle.
module alu_rs #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int NAME_W  = 5,
  parameter int OP_W    = 5,
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_rs_if.slave  bus
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } opd_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    opd_t              o1;
    opd_t              o2;
    logic [TAG_W-1:0]  wtag;
    logic [NAME_W-1:0] wname;
  } ent_t;

  ent_t ent_q [ENTRIES];
  ent_t ent_d [ENTRIES];

  logic             full;
  logic             sel_hit;
  logic [IDX_W-1:0] sel;
  logic             free_hit;
  logic [IDX_W-1:0] free;
  logic             disp_ok;

  // cdbA is checked first so it wins when both buses carry the same tag
  function automatic opd_t snoop(input opd_t o);
    opd_t r;
    r = o;
    if (o.tag != '0) begin
      if (bus.cdbAEn && bus.cdbATag == o.tag)
        r = '{tag: '0, data: bus.cdbAData};
      else if (bus.cdbLEn && bus.cdbLTag == o.tag)
        r = '{tag: '0, data: bus.cdbLData};
    end
    return r;
  endfunction

  always_comb begin
    full     = 1'b1;
    sel_hit  = 1'b0;
    sel      = '0;
    free_hit = 1'b0;
    free     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        full     = 1'b0;
        free_hit = 1'b1;
        free     = IDX_W'(i);
      end
      if (ent_q[i].valid && ent_q[i].o1.tag == '0
          && ent_q[i].o2.tag == '0) begin
        sel_hit = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  assign disp_ok    = bus.dispEn && !full && !flush;
  assign bus.rsFull = full;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        ent_d[i].o1 = snoop(ent_q[i].o1);
        ent_d[i].o2 = snoop(ent_q[i].o2);
      end
    end
    if (sel_hit)
      ent_d[sel].valid = 1'b0;
    // the slot freed by this cycle's issue is never the dispatch target
    if (disp_ok && free_hit) begin
      ent_d[free].valid = 1'b1;
      ent_d[free].op    = bus.dispOp;
      ent_d[free].o1    = snoop('{tag: bus.dispTagO,
                                  data: bus.dispDataO});
      ent_d[free].o2    = snoop('{tag: bus.dispTagT,
                                  data: bus.dispDataT});
      ent_d[free].wtag  = bus.dispWrtTag;
      ent_d[free].wname = bus.dispWrtName;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < ENTRIES; i++)
        ent_q[i] <= '0;
      bus.ALUworkEn <= 1'b0;
      bus.operandO  <= '0;
      bus.operandT  <= '0;
      bus.wrtTag    <= '0;
      bus.wrtName   <= '0;
      bus.opCode    <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        ent_q[i] <= ent_d[i];
      bus.ALUworkEn <= sel_hit;
      if (sel_hit) begin
        bus.operandO <= ent_q[sel].o1.data;
        bus.operandT <= ent_q[sel].o2.data;
        bus.wrtTag   <= ent_q[sel].wtag;
        bus.wrtName  <= ent_q[sel].wname;
        bus.opCode   <= ent_q[sel].op;
      end else begin
        bus.operandO <= '0;
        bus.operandT <= '0;
        bus.wrtTag   <= '0;
        bus.wrtName  <= '0;
        bus.opCode   <= '0;
      end
    end
  end

endmodule
